// File: rtl/taumin_uart_reporter.sv
// taumin_uart_reporter: reports each taumin value as "XXXX\n" ASCII hex over UART 8N1.
module taumin_uart_reporter #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int TAU_WIDTH = 11
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [TAU_WIDTH-1:0] taumin_in,
  input  logic                 taumin_valid_in,
  output logic                 uart_txd_out,
  output logic                 busy_out,
  output logic [7:0]           drop_count_out
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d, byte_q, byte_d;
  logic [15:0]   active_q, active_d, pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [7:0]    drop_q, drop_d;
  logic          txd_q, txd_d, busy_q, busy_d;
  logic          tick, frame_end, busy;
  logic [15:0]   tau16, shifted;
  logic [3:0]    nib;
  logic [7:0]    cur;
  always_comb begin
    tau16       = 16'(taumin_in);
    tick        = cnt_q == CW'(DIV - 1);
    busy        = state_q != S_IDLE;
    frame_end   = state_q == S_STOP && tick && byte_q == 3'd4;
    state_d     = state_q;
    cnt_d       = (state_q == S_IDLE || tick) ? '0 : cnt_q + CW'(1);
    bit_d       = bit_q;
    byte_d      = byte_q;
    active_d    = active_q;
    case (state_q)
      S_IDLE: if (taumin_valid_in) begin
        state_d  = S_START;
        active_d = tau16;
        byte_d   = '0;
        bit_d    = '0;
      end
      S_START: if (tick) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (tick) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end
      default: if (tick) begin
        if (byte_q != 3'd4) begin
          state_d = S_START;
          byte_d  = byte_q + 3'd1;
        end else if (taumin_valid_in || pend_full_q) begin
          state_d  = S_START;
          byte_d   = '0;
          active_d = taumin_valid_in ? tau16 : pend_q;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    // At frame end the pending slot is either consumed or superseded (and counted as dropped).
    pend_d      = (busy && taumin_valid_in && !frame_end) ? tau16 : pend_q;
    pend_full_d = frame_end ? 1'b0 : (busy && taumin_valid_in) ? 1'b1 : pend_full_q;
    drop_d      = (busy && taumin_valid_in && pend_full_q && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    shifted     = active_d << {byte_d[1:0], 2'b00};
    nib         = shifted[15:12];
    cur         = byte_d == 3'd4 ? 8'h0A : nib < 4'd10 ? {4'h3, nib} : 8'h37 + {4'h0, nib};
    txd_d       = state_d == S_START ? 1'b0 : state_d == S_DATA ? cur[bit_d] : 1'b1;
    busy_d      = state_d != S_IDLE;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      drop_q      <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      drop_q      <= drop_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
    end
  end
  assign uart_txd_out   = txd_q;
  assign busy_out       = busy_q;
  assign drop_count_out = drop_q;
endmodule

// File: tb/tb_taumin_uart_reporter.sv
// tb_taumin_uart_reporter: directed vectors for the taumin UART reporter at DIV=10.
module tb_taumin_uart_reporter;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] taumin_in = '0;
  logic        taumin_valid_in = 1'b0;
  logic        uart_txd_out, busy_out;
  logic [7:0]  drop_count_out;
  int          nvec = 0;
  int          nfail = 0;
  logic        txd_a [0:2047];
  logic        busy_a [0:2047];
  logic [10:0] inj [int];
  typedef struct {
    logic [10:0] tau;
    logic [39:0] exp;
  } vec_t;
  vec_t vecs [5];

  taumin_uart_reporter #(.CLK_HZ(1000), .BAUD(100), .TAU_WIDTH(11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .taumin_in(taumin_in), .taumin_valid_in(taumin_valid_in),
    .uart_txd_out(uart_txd_out), .busy_out(busy_out), .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sample at each negedge i, then drive the strobe for the following posedge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      txd_a[i]  = uart_txd_out;
      busy_a[i] = busy_out;
      taumin_valid_in = inj.exists(i);
      taumin_in = inj.exists(i) ? inj[i] : 11'h0;
    end
    taumin_valid_in = 1'b0;
    inj.delete();
  endtask

  // Frame whose first start-bit cycle is at negedge s+1; each bit sampled mid-period.
  task automatic chk_frame(input string name, input int s, input logic [39:0] exp);
    logic [7:0] b;
    logic       framing;
    framing = 1'b1;
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 8; k++) b[k] = txd_a[s + 1 + 10 * (10 * j + 1 + k) + 5];
      framing &= txd_a[s + 1 + 10 * (10 * j) + 5] == 1'b0;
      framing &= txd_a[s + 1 + 10 * (10 * j + 9) + 5] == 1'b1;
      chk($sformatf("%s byte%0d", name, j), int'(b), int'(exp[39 - 8 * j -: 8]));
    end
    chk($sformatf("%s framing", name), int'(framing), 1);
  endtask

  function automatic int busy_count(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(busy_a[i]);
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    vecs[0] = '{11'h7A5, 40'h30_37_41_35_0A};
    vecs[1] = '{11'h7FF, 40'h30_37_46_46_0A};
    vecs[2] = '{11'h000, 40'h30_30_30_30_0A};
    vecs[3] = '{11'h123, 40'h30_31_32_33_0A};
    vecs[4] = '{11'h4C9, 40'h30_34_43_39_0A};
    repeat (2) @(negedge clk_in);
    chk("reset txd", int'(uart_txd_out), 1);
    chk("reset busy", int'(busy_out), 0);
    chk("reset drop", int'(drop_count_out), 0);
    rst_in = 1'b1;

    foreach (vecs[v]) begin
      inj[0] = vecs[v].tau;
      run(520);
      chk($sformatf("v%0d idle before", v), int'(txd_a[0]), 1);
      chk($sformatf("v%0d txd low next", v), int'(txd_a[1]), 0);
      chk($sformatf("v%0d busy rise", v), int'(busy_a[1]), 1);
      chk($sformatf("v%0d busy cycles", v), busy_count(520), 500);
      chk($sformatf("v%0d busy fall", v), int'(busy_a[501]), 0);
      chk_frame($sformatf("v%0d", v), 0, vecs[v].exp);
    end

    do_reset();
    inj[0] = 11'h100;
    inj[100] = 11'h200;
    run(1020);
    chk_frame("b2b first", 0, 40'h30_31_30_30_0A);
    chk_frame("b2b second", 500, 40'h30_32_30_30_0A);
    chk("b2b busy cycles", busy_count(1020), 1000);
    chk("b2b busy end", int'(busy_a[1001]), 0);
    chk("b2b drop", int'(drop_count_out), 0);

    do_reset();
    inj[0] = 11'h001;
    inj[10] = 11'h002;
    inj[20] = 11'h003;
    run(1020);
    chk_frame("ovr first", 0, 40'h30_30_30_31_0A);
    chk_frame("ovr second", 500, 40'h30_30_30_33_0A);
    chk("ovr drop", int'(drop_count_out), 1);
    chk("ovr busy cycles", busy_count(1020), 1000);

    do_reset();
    for (int i = 0; i <= 300; i++) inj[i] = 11'(i + 1);
    run(1020);
    chk("sat drop", int'(drop_count_out), 255);
    chk_frame("sat second", 500, 40'h30_31_32_44_0A);

    do_reset();
    inj[0] = 11'h7A5;
    inj[100] = 11'h0AA;
    inj[500] = 11'h055;
    run(1020);
    chk_frame("edge first", 0, 40'h30_37_41_35_0A);
    chk_frame("edge second", 500, 40'h30_30_35_35_0A);
    chk("edge drop", int'(drop_count_out), 1);
    chk("edge busy end", int'(busy_a[1001]), 0);

    do_reset();
    inj[0] = 11'h7A5;
    inj[50] = 11'h111;
    inj[60] = 11'h222;
    run(226);
    chk("pre-abort drop", int'(drop_count_out), 1);
    rst_in = 1'b0;
    #1;
    chk("abort txd", int'(uart_txd_out), 1);
    chk("abort busy", int'(busy_out), 0);
    chk("abort drop", int'(drop_count_out), 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    inj[0] = 11'h123;
    run(520);
    chk_frame("post-abort", 0, 40'h30_31_32_33_0A);
    chk("post-abort busy cycles", busy_count(520), 500);
    chk("post-abort busy end", int'(busy_a[501]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/taumin_uart_reporter.md
Name: taumin_uart_reporter

Overview:
Downstream consumer of the pitch detector's registered taumin stream; drives the board's uart_txd pin.
Each accepted taumin value is reported as a 5-byte ASCII line: 4 upper-case hex digits of the zero-extended 16-bit value, then '\n' (0x0A).
Sent as UART 8N1, LSB first. Gives host-side logging of detected pitch period without disturbing the audio path.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz
BAUD, 115200, UART bit rate; bit period DIV = CLK_HZ/BAUD, integer floor (868 at defaults), DIV >= 2 required
TAU_WIDTH, 11, width of taumin_in, 1..16; zero-extended to 16 bits before hex conversion

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low (0 = reset)
taumin_in  input  TAU_WIDTH  pitch period in samples, valid when taumin_valid_in=1
taumin_valid_in  input  1  single-cycle strobe; no backpressure, never stalled
uart_txd_out  output  1  serial line, idles high
busy_out  output  1  high while a frame is being shifted out
drop_count_out  output  8  saturating count of values overwritten in the pending slot

Behaviour:
- Reset (async assert, sync release): uart_txd_out=1, busy_out=0, drop_count_out=0, pending slot empty, FSM=IDLE, all counters 0.
- Storage: one active frame register (16 bits) plus one pending slot (16 bits + full flag). Newest value always wins.
- FSM states:
  - IDLE -> START on taumin_valid_in; value captured into active register.
  - START: txd=0 for DIV cycles.
  - DATA: 8 bits, each DIV cycles, LSB first.
  - STOP: txd=1 for DIV cycles.
  - After STOP, byte index 0..3 -> next byte (START); byte index 4 -> frame end.
- Latency: uart_txd_out falls on the first clk_in edge after the cycle that sampled taumin_valid_in in IDLE. busy_out rises on the same edge.
- Byte n (n=0..3) = ASCII of nibble [15-4n:12-4n]: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46. Byte 4 = 0x0A.
- No inter-byte gap. Frame length exactly 50*DIV cycles.
- Valid while busy:
  - pending empty -> store, set full.
  - pending full -> overwrite, drop_count_out += 1, saturating at 255.
- Frame end (last STOP cycle), next frame source priority: taumin_valid_in this cycle > pending slot.
  - If both present: pending counts as dropped (+1) and is cleared.
  - If a next value exists: START begins on the next edge, busy_out stays 1, no idle bit inserted.
  - Otherwise -> IDLE, busy_out=0.
- Valid in the same cycle IDLE starts: captured directly into the active register; pending untouched.
- Reset mid-frame: uart_txd_out=1 immediately (async). Partial frame abandoned, not resumed; pending and drop count cleared.
- Outputs are registered; uart_txd_out is glitch-free.

Test Plan:
- CLK_HZ=1000, BAUD=100 (DIV=10); one strobe with taumin_in=0x7A5 -> bytes 0x30,0x37,0x41,0x35,0x0A.
  - Each byte: start bit 10 cycles, LSB-first data, stop bit.
  - busy_out high exactly 500 cycles; txd low one cycle after the strobe.
- TAU_WIDTH=11, taumin_in=0x7FF -> "07FF\n". taumin_in=0 -> "0000\n" (0x30 x4, 0x0A).
- Strobe 0x100, then 0x200 at cycle 100 -> "0100\n" then "0200\n".
  - Second frame's start bit begins the cycle after the first frame's last stop cycle; busy_out never drops; drop_count_out=0.
- Strobes 0x001, 0x002, 0x003 during one frame -> "0001\n", then "0003\n"; drop_count_out=1.
  - 300 overwrites -> drop_count_out stays 255.
- Strobe on the exact last STOP cycle, pending holding 0x0AA, new value 0x055 -> next frame "0055\n"; drop_count_out +1.
- rst_in=0 during DATA of byte 2 -> txd=1 and busy_out=0 within the same cycle.
  - After release, a fresh strobe 0x123 -> complete "0123\n"; no residue of the aborted frame.
